// File: rtl/fir_tap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_tap_pkg
// Purpose  : Shared types and default coefficient sets for the FIR chain
//            (fir_direct / poly_deci / poly_intp) and its tap loader.
// Contents : ldr_state_t  - loader FSM state
//            TAP_LP010    - 21-tap Hamming low-pass, fc = 0.1 fs, Q1.15
//            TAP_LP008    - 21-tap Hamming low-pass, fc = 0.08 fs, Q1.15
// Revision : 1.0 - initial release
// ============================================================================
package fir_tap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } ldr_state_t;

    // Symmetric sets, listed tap[20] down to tap[0]; DC gain normalised to 1.0.
    localparam logic [20:0][15:0] TAP_LP010 = {
        16'h0000, 16'hFFBA, 16'hFF31, 16'hFE84, 16'hFE6B, 16'h0000, 16'h0411,
        16'h0A6D, 16'h1199, 16'h1750, 16'h197E, 16'h1750, 16'h1199, 16'h0A6D,
        16'h0411, 16'h0000, 16'hFE6B, 16'hFE84, 16'hFF31, 16'hFFBA, 16'h0000
    };

    localparam logic [20:0][15:0] TAP_LP008 = {
        16'hFFB0, 16'hFF8A, 16'hFF55, 16'hFF6B, 16'h0058, 16'h029D, 16'h065B,
        16'h0B1A, 16'h0FDC, 16'h1366, 16'h14B4, 16'h1366, 16'h0FDC, 16'h0B1A,
        16'h065B, 16'h029D, 16'h0058, 16'hFF6B, 16'hFF55, 16'hFF8A, 16'hFFB0
    };

endpackage
`default_nettype wire

// File: rtl/tap_bank.sv
`default_nettype none
// ============================================================================
// Module   : tap_bank
// Purpose  : TAP_LEN x WIDTH coefficient register array. One word can be
//            written by index, or the whole array loaded in parallel; the
//            parallel load has priority.
// Ports    : clk_i      - clock, rising edge
//            rst_ni     - asynchronous reset, active low (loads RST_VAL)
//            wr_en_i    - write wr_data_i into entry wr_idx_i
//            wr_idx_i   - entry index for single-word write
//            wr_data_i  - single-word write data
//            ld_en_i    - load ld_data_i into every entry
//            ld_data_i  - parallel load data
//            taps_o     - current contents (registered)
// Revision : 1.0 - initial release
// ============================================================================
module tap_bank #(
    parameter int TAP_LEN = 21,
    parameter int WIDTH   = 16,
    parameter int IDX_W   = 5,
    parameter logic [TAP_LEN-1:0][WIDTH-1:0] RST_VAL = '0
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            wr_en_i,
    input  logic [IDX_W-1:0]                wr_idx_i,
    input  logic [WIDTH-1:0]                wr_data_i,
    input  logic                            ld_en_i,
    input  logic [TAP_LEN-1:0][WIDTH-1:0]   ld_data_i,
    output logic [TAP_LEN-1:0][WIDTH-1:0]   taps_o
);

    logic [TAP_LEN-1:0][WIDTH-1:0] taps_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            taps_q <= RST_VAL;
        end else if (ld_en_i) begin
            taps_q <= ld_data_i;
        end else if (wr_en_i && (wr_idx_i < IDX_W'(TAP_LEN))) begin
            taps_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign taps_o = taps_q;

endmodule
`default_nettype wire

// File: rtl/fir_tap_loader.sv
`default_nettype none
// ============================================================================
// Module   : fir_tap_loader
// Purpose  : Run-time coefficient controller. A new tap set streams into a
//            shadow bank; once complete it is copied atomically into the
//            active bank on the next filter sample strobe, so the filter never
//            sees a half-updated tap vector.
// Ports    : clk_i       - clock, rising edge
//            rst_ni      - asynchronous reset, active low
//            wr_valid_i  - coefficient word valid
//            wr_ready_o  - loader accepts a word this cycle
//            wr_data_i   - coefficient; first word -> tap[0]
//            wr_last_i   - final word of a set
//            sync_i      - sample strobe of the filter being configured
//            tap_o       - active coefficient bank (registered)
//            busy_o      - loading or armed
//            swapped_o   - one-cycle pulse, first cycle the new set is on tap_o
//            len_err_o   - sticky set-length error, cleared by next first word
// Revision : 1.0 - initial release
// ============================================================================
module fir_tap_loader
    import fir_tap_pkg::*;
#(
    parameter int TAP_LEN = 21,
    parameter int WIDTH   = 16,
    parameter logic [TAP_LEN-1:0][WIDTH-1:0] RST_TAPS = TAP_LP010
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            wr_valid_i,
    output logic                            wr_ready_o,
    input  logic [WIDTH-1:0]                wr_data_i,
    input  logic                            wr_last_i,
    input  logic                            sync_i,
    output logic [TAP_LEN-1:0][WIDTH-1:0]   tap_o,
    output logic                            busy_o,
    output logic                            swapped_o,
    output logic                            len_err_o
);

    localparam int                c_idx_w    = (TAP_LEN > 1) ? $clog2(TAP_LEN) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(TAP_LEN - 1);

    ldr_state_t                     state_q, state_d;
    logic [c_idx_w-1:0]             idx_q, idx_d;
    logic                           len_err_q, len_err_d;
    logic                           swapped_q;
    logic                           wr_ready_q;

    logic                           w_hs;
    logic                           w_sh_we;
    logic                           w_commit;
    logic [TAP_LEN-1:0][WIDTH-1:0]  w_shadow;

    assign w_hs = wr_valid_i & wr_ready_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_err_d = len_err_q;
        w_sh_we   = 1'b0;
        w_commit  = 1'b0;
        case (state_q)
            // idx_q is always 0 in IDLE, so both states share the word path.
            IDLE, LOAD: begin
                if (w_hs) begin
                    w_sh_we = 1'b1;
                    if (state_q == IDLE) begin
                        len_err_d = 1'b0;
                    end
                    if (idx_q == c_last_idx) begin
                        idx_d = '0;
                        if (wr_last_i) begin
                            state_d = ARMED;
                        end else begin
                            len_err_d = 1'b1;
                            state_d   = IDLE;
                        end
                    end else if (wr_last_i) begin
                        idx_d     = '0;
                        len_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        idx_d   = idx_q + c_idx_w'(1);
                        state_d = LOAD;
                    end
                end
            end
            ARMED: begin
                if (sync_i) begin
                    w_commit = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // wr_ready is registered from the next state so it is low during reset
    // and falls on exactly the cycles spent in ARMED.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_err_q  <= 1'b0;
            swapped_q  <= 1'b0;
            wr_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_err_q  <= len_err_d;
            swapped_q  <= w_commit;
            wr_ready_q <= (state_d != ARMED);
        end
    end

    tap_bank #(
        .TAP_LEN (TAP_LEN),
        .WIDTH   (WIDTH),
        .IDX_W   (c_idx_w),
        .RST_VAL (RST_TAPS)
    ) u_shadow (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (w_sh_we),
        .wr_idx_i  (idx_q),
        .wr_data_i (wr_data_i),
        .ld_en_i   (1'b0),
        .ld_data_i ('0),
        .taps_o    (w_shadow)
    );

    tap_bank #(
        .TAP_LEN (TAP_LEN),
        .WIDTH   (WIDTH),
        .IDX_W   (c_idx_w),
        .RST_VAL (RST_TAPS)
    ) u_active (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (1'b0),
        .wr_idx_i  ('0),
        .wr_data_i ('0),
        .ld_en_i   (w_commit),
        .ld_data_i (w_shadow),
        .taps_o    (tap_o)
    );

    assign wr_ready_o = wr_ready_q;
    assign busy_o     = (state_q != IDLE);
    assign swapped_o  = swapped_q;
    assign len_err_o  = len_err_q;

endmodule
`default_nettype wire
